// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the instruction word width, the default PC/reset/halt constants
// shared with the decoder and memory, and the instruction word type.
package instr_fetch_unit_pkg;

   localparam int          INSTR_W       = 32;
   localparam int          PC_W_DEF      = 32;
   localparam int          RESET_PC_DEF  = 0;
   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

   typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus between the fetch unit and a word-addressed,
// combinational-read instruction memory.
//   imem_addr  : word address presented by the fetch unit
//   imem_instr : instruction word returned combinationally for imem_addr
// Modports: master = fetch unit, slave = memory.
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);
   logic [PC_W-1:0] imem_addr;
   instr_t          imem_instr;

   modport master (output imem_addr, input imem_instr);
   modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/instr_fetch_unit_sat_counter.sv
// Saturating up-counter used for the fetch and stall performance counters.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears q
//   inc   : count one event this cycle
//   q     : current count, sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage of the pipeline: owns the PC, drives the instruction memory
// address, and captures the returned word into the IF/ID register.
// Ports:
//   clk, rst_n       : clock and synchronous active-low reset
//   imem             : instruction memory bus (master side)
//   stall_i          : hold PC and IF/ID this cycle
//   redirect_i       : load redirect_pc_i into the PC and squash IF/ID
//   redirect_pc_i    : redirect target (word address)
//   if_id_valid      : IF/ID holds a real instruction
//   if_id_instr      : captured instruction, 0 for a bubble
//   if_id_pc         : PC of if_id_instr
//   halted           : fetch stopped on the halt word or an address error
//   addr_err         : sticky, fetch attempted beyond the memory
//   fetch_cnt        : saturating count of captured instructions
//   stall_cnt        : saturating count of honoured stall cycles
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          PC_W      = PC_W_DEF,
   parameter int          MEM_DEPTH = 256,
   parameter int          RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
   parameter int          CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_unit_if.master  imem,
   input  logic                stall_i,
   input  logic                redirect_i,
   input  logic [PC_W-1:0]     redirect_pc_i,
   output logic                if_id_valid,
   output instr_t              if_id_instr,
   output logic [PC_W-1:0]     if_id_pc,
   output logic                halted,
   output logic                addr_err,
   output logic [CNT_W-1:0]    fetch_cnt,
   output logic [CNT_W-1:0]    stall_cnt
);

   // Compare at PC_W+1 bits so a MEM_DEPTH of 2^PC_W cannot alias to 0.
   localparam logic [PC_W:0]   DEPTH_X  = (PC_W+1)'(MEM_DEPTH);
   localparam logic [PC_W-1:0] RESET_PC_L = PC_W'(RESET_PC);

   logic [PC_W-1:0] pc_q;
   logic            out_of_range;
   logic            is_halt;
   logic            fetch_inc;
   logic            stall_inc;

   assign imem.imem_addr = pc_q;

   assign out_of_range = ({1'b0, pc_q} >= DEPTH_X);
   assign is_halt      = (imem.imem_instr == HALT_WORD);

   // Counter enables follow the same priority order as the PC update below.
   assign stall_inc = !redirect_i && !halted && stall_i;
   assign fetch_inc = !redirect_i && !halted && !stall_i && !out_of_range && !is_halt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC_L;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         if_id_pc    <= '0;
         halted      <= 1'b0;
         addr_err    <= 1'b0;
      end else if (redirect_i) begin
         // Squash IF/ID; the target word is captured on the following edge.
         pc_q        <= redirect_pc_i;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         halted      <= 1'b0;
      end else if (halted || stall_i) begin
         // Hold everything.
      end else if (out_of_range) begin
         // imem_instr is meaningless here and must not be captured.
         addr_err    <= 1'b1;
         halted      <= 1'b1;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
      end else if (is_halt) begin
         // PC keeps pointing at the sentinel.
         halted      <= 1'b1;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
      end else begin
         if_id_valid <= 1'b1;
         if_id_instr <= imem.imem_instr;
         if_id_pc    <= pc_q;
         pc_q        <= pc_q + PC_W'(1);
      end
   end

   sat_counter #(.W(CNT_W)) u_fetch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (fetch_inc),
      .q     (fetch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .q     (stall_cnt)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: default parameters
   logic        rst_n = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        if_id_valid;
   instr_t      if_id_instr;
   logic [31:0] if_id_pc;
   logic        halted;
   logic        addr_err;
   logic [15:0] fetch_cnt;
   logic [15:0] stall_cnt;

   instr_fetch_unit_if #(.PC_W(32)) bus_a ();

   instr_fetch_unit #(.PC_W(32), .MEM_DEPTH(256), .RESET_PC(0), .HALT_WORD(HALT), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (bus_a),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc      (if_id_pc),
      .halted        (halted),
      .addr_err      (addr_err),
      .fetch_cnt     (fetch_cnt),
      .stall_cnt     (stall_cnt)
   );

   // DUT B: 4-bit counters for the saturation test
   logic        rst_n_b = 1'b0;
   logic        if_id_valid_b;
   instr_t      if_id_instr_b;
   logic [31:0] if_id_pc_b;
   logic        halted_b;
   logic        addr_err_b;
   logic [3:0]  fetch_cnt_b;
   logic [3:0]  stall_cnt_b;

   instr_fetch_unit_if #(.PC_W(32)) bus_b ();

   instr_fetch_unit #(.PC_W(32), .MEM_DEPTH(256), .RESET_PC(0), .HALT_WORD(HALT), .CNT_W(4)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n_b),
      .imem          (bus_b),
      .stall_i       (1'b0),
      .redirect_i    (1'b0),
      .redirect_pc_i (32'd0),
      .if_id_valid   (if_id_valid_b),
      .if_id_instr   (if_id_instr_b),
      .if_id_pc      (if_id_pc_b),
      .halted        (halted_b),
      .addr_err      (addr_err_b),
      .fetch_cnt     (fetch_cnt_b),
      .stall_cnt     (stall_cnt_b)
   );

   // Memory model: word 29 is the halt sentinel, beyond 255 returns junk.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a >= 32'd256)    return 32'h0BAD_0BAD;
      else if (a == 32'd29) return HALT;
      else                 return 32'h1000_0000 | (a * 32'd7);
   endfunction

   always_comb bus_a.imem_instr = mem_word(bus_a.imem_addr);
   always_comb bus_b.imem_instr = mem_word(bus_b.imem_addr);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc, halted, addr_err} !== 67'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b i=%h pc=%0d h=%b ae=%b, want all 0",
                  if_id_valid, if_id_instr, if_id_pc, halted, addr_err);
      end
      checks++;
      if (bus_a.imem_addr !== 32'd0 || fetch_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_pc_cnt: got addr=%0d fc=%0d sc=%0d, want 0 0 0",
                  bus_a.imem_addr, fetch_cnt, stall_cnt);
      end
   endtask

   task automatic test_sequential();
      exp_t e;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sb.push_back('{v: 1'b1, instr: mem_word(32'(k)), pc: 32'(k)});
         tick();
         e = sb.pop_front();
         checks++;
         if ({if_id_valid, if_id_instr, if_id_pc} !== e) begin
            errors++;
            $display("FAIL seq_fetch[%0d]: got v=%b i=%h pc=%0d, want v=%b i=%h pc=%0d",
                     k, if_id_valid, if_id_instr, if_id_pc, e.v, e.instr, e.pc);
         end
      end
      checks++;
      if (fetch_cnt !== 16'd4 || bus_a.imem_addr !== 32'd4) begin
         errors++;
         $display("FAIL seq_count: got fc=%0d addr=%0d, want 4 4", fetch_cnt, bus_a.imem_addr);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      stall_i = 1'b1;
      tick();
      tick();
      checks++;
      if (if_id_pc !== 32'd3 || bus_a.imem_addr !== 32'd4 || stall_cnt !== 16'd2 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold: got pc=%0d addr=%0d sc=%0d v=%b, want 3 4 2 1",
                  if_id_pc, bus_a.imem_addr, stall_cnt, if_id_valid);
      end
      stall_i = 1'b0;
      sb.push_back('{v: 1'b1, instr: mem_word(32'd4), pc: 32'd4});
      tick();
      e = sb.pop_front();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc} !== e) begin
         errors++;
         $display("FAIL stall_release: got v=%b i=%h pc=%0d, want v=%b i=%h pc=%0d",
                  if_id_valid, if_id_instr, if_id_pc, e.v, e.instr, e.pc);
      end
   endtask

   task automatic test_redirect_stall();
      exp_t e;
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd20;
      tick();
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || bus_a.imem_addr !== 32'd20 || stall_cnt !== 16'd2) begin
         errors++;
         $display("FAIL redir_bubble: got v=%b i=%h addr=%0d sc=%0d, want 0 0 20 2",
                  if_id_valid, if_id_instr, bus_a.imem_addr, stall_cnt);
      end
      sb.push_back('{v: 1'b1, instr: mem_word(32'd20), pc: 32'd20});
      tick();
      e = sb.pop_front();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc} !== e) begin
         errors++;
         $display("FAIL redir_target: got v=%b i=%h pc=%0d, want v=%b i=%h pc=%0d",
                  if_id_valid, if_id_instr, if_id_pc, e.v, e.instr, e.pc);
      end
   endtask

   task automatic test_halt();
      exp_t e;
      for (int k = 21; k < 29; k++) begin
         sb.push_back('{v: 1'b1, instr: mem_word(32'(k)), pc: 32'(k)});
         tick();
         e = sb.pop_front();
         checks++;
         if ({if_id_valid, if_id_instr, if_id_pc} !== e) begin
            errors++;
            $display("FAIL pre_halt[%0d]: got v=%b i=%h pc=%0d, want pc=%0d", k,
                     if_id_valid, if_id_instr, if_id_pc, e.pc);
         end
      end
      tick();
      checks++;
      if (halted !== 1'b1 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 ||
          bus_a.imem_addr !== 32'd29 || fetch_cnt !== 16'd14) begin
         errors++;
         $display("FAIL halt_enter: got h=%b v=%b i=%h addr=%0d fc=%0d, want 1 0 0 29 14",
                  halted, if_id_valid, if_id_instr, bus_a.imem_addr, fetch_cnt);
      end
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      stall_i = 1'b0;
      tick();
      checks++;
      if (halted !== 1'b1 || bus_a.imem_addr !== 32'd29 || fetch_cnt !== 16'd14 || stall_cnt !== 16'd2) begin
         errors++;
         $display("FAIL halt_frozen: got h=%b addr=%0d fc=%0d sc=%0d, want 1 29 14 2",
                  halted, bus_a.imem_addr, fetch_cnt, stall_cnt);
      end
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd0;
      tick();
      redirect_i = 1'b0;
      checks++;
      if (halted !== 1'b0 || if_id_valid !== 1'b0 || bus_a.imem_addr !== 32'd0) begin
         errors++;
         $display("FAIL halt_clear: got h=%b v=%b addr=%0d, want 0 0 0",
                  halted, if_id_valid, bus_a.imem_addr);
      end
      sb.push_back('{v: 1'b1, instr: mem_word(32'd0), pc: 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc} !== e || fetch_cnt !== 16'd15) begin
         errors++;
         $display("FAIL halt_refetch: got v=%b i=%h pc=%0d fc=%0d, want v=1 i=%h pc=0 fc=15",
                  if_id_valid, if_id_instr, if_id_pc, fetch_cnt, e.instr);
      end
   endtask

   task automatic test_addr_err();
      exp_t e;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd300;
      tick();
      redirect_i = 1'b0;
      checks++;
      if (bus_a.imem_addr !== 32'd300 || addr_err !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL aerr_redirect: got addr=%0d ae=%b h=%b, want 300 0 0",
                  bus_a.imem_addr, addr_err, halted);
      end
      tick();
      checks++;
      if (addr_err !== 1'b1 || halted !== 1'b1 || if_id_valid !== 1'b0 || fetch_cnt !== 16'd15) begin
         errors++;
         $display("FAIL aerr_set: got ae=%b h=%b v=%b fc=%0d, want 1 1 0 15",
                  addr_err, halted, if_id_valid, fetch_cnt);
      end
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd0;
      tick();
      redirect_i = 1'b0;
      checks++;
      if (halted !== 1'b0 || addr_err !== 1'b1) begin
         errors++;
         $display("FAIL aerr_sticky: got h=%b ae=%b, want 0 1", halted, addr_err);
      end
      sb.push_back('{v: 1'b1, instr: mem_word(32'd0), pc: 32'd0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc} !== e) begin
         errors++;
         $display("FAIL aerr_refetch: got v=%b i=%h pc=%0d, want v=1 i=%h pc=0",
                  if_id_valid, if_id_instr, if_id_pc, e.instr);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      stall_i = 1'b1;
      rst_n   = 1'b0;
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc, halted, addr_err} !== 67'd0 ||
          fetch_cnt !== 16'd0 || stall_cnt !== 16'd0 || bus_a.imem_addr !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: got v=%b i=%h pc=%0d h=%b ae=%b fc=%0d sc=%0d addr=%0d, want all 0",
                  if_id_valid, if_id_instr, if_id_pc, halted, addr_err, fetch_cnt, stall_cnt,
                  bus_a.imem_addr);
      end
      stall_i = 1'b0;
      rst_n   = 1'b1;
   endtask

   task automatic test_counter_sat();
      rst_n_b = 1'b0;
      tick();
      rst_n_b = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      checks++;
      if (fetch_cnt_b !== 4'd15 || stall_cnt_b !== 4'd0) begin
         errors++;
         $display("FAIL cnt_saturate: got fc=%0d sc=%0d, want 15 0", fetch_cnt_b, stall_cnt_b);
      end
      checks++;
      if (if_id_pc_b !== 32'd19 || if_id_valid_b !== 1'b1 || if_id_instr_b !== mem_word(32'd19) ||
          halted_b !== 1'b0 || addr_err_b !== 1'b0) begin
         errors++;
         $display("FAIL cnt_pipeline: got pc=%0d v=%b i=%h h=%b ae=%b, want 19 1 %h 0 0",
                  if_id_pc_b, if_id_valid_b, if_id_instr_b, halted_b, addr_err_b, mem_word(32'd19));
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_stall();
      test_halt();
      test_addr_err();
      test_reset_mid();
      test_counter_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
